// File: rtl/uart_frame_bit_counter.sv
// Frame bit counter for the UART shifter: counts len_q bit periods of OVERSAMPLE baud ticks each.
// Optional back-to-back frame reload when UART_BIT_COUNTER_RELOAD_EN is defined.
module uart_frame_bit_counter #(
    parameter int unsigned MAX_BITS   = 12,
    parameter int unsigned OVERSAMPLE = 1,
    localparam int unsigned LEN_W     = $clog2(MAX_BITS + 1),
    localparam int unsigned OS_W      = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             tick_i,
    output logic             busy_o,
    output logic [LEN_W-1:0] bit_idx_o,
    output logic             bit_strobe_o,
    output logic             last_bit_o,
    output logic             done_o
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BITS);
    localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);

    typedef enum logic {
        S_IDLE,
        S_COUNT
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [LEN_W-1:0] r_idx;
    logic [LEN_W-1:0] w_idx_nx;
    logic [OS_W-1:0]  r_sub;
    logic [OS_W-1:0]  w_sub_nx;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] w_len_nx;
    logic             r_strobe;
    logic             w_strobe_nx;
    logic             r_done;
    logic             w_done_nx;

    logic             w_start_ok;
    logic [LEN_W-1:0] w_len_sat;
    logic             w_last_idx;
    logic             w_bit_end;

    assign w_start_ok = start_i && (len_i != '0);
    assign w_len_sat  = (len_i > MAX_LEN) ? MAX_LEN : len_i;
    assign w_last_idx = (r_idx == (r_len - LEN_W'(1)));
    assign w_bit_end  = tick_i && (r_sub == OS_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_sub    <= '0;
            r_len    <= '0;
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_idx    <= w_idx_nx;
            r_sub    <= w_sub_nx;
            r_len    <= w_len_nx;
            r_strobe <= w_strobe_nx;
            r_done   <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_idx_nx    = r_idx;
        w_sub_nx    = r_sub;
        w_len_nx    = r_len;
        w_strobe_nx = 1'b0;
        w_done_nx   = 1'b0;

        if (clear_i) begin
            w_state_nx = S_IDLE;
            w_idx_nx   = '0;
            w_sub_nx   = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        w_state_nx = S_COUNT;
                        w_len_nx   = w_len_sat;
                        w_idx_nx   = '0;
                        w_sub_nx   = '0;
                    end
                end
                S_COUNT: begin
                    if (w_bit_end) begin
                        w_sub_nx    = '0;
                        w_strobe_nx = 1'b1;
                        if (w_last_idx) begin
                            w_done_nx = 1'b1;
`ifdef UART_BIT_COUNTER_RELOAD_EN
                            // A start on the final tick chains the next frame with no IDLE gap.
                            if (w_start_ok) begin
                                w_len_nx = w_len_sat;
                                w_idx_nx = '0;
                            end else begin
                                w_state_nx = S_IDLE;
                            end
`else
                            w_state_nx = S_IDLE;
`endif
                        end else begin
                            w_idx_nx = r_idx + LEN_W'(1);
                        end
                    end else if (tick_i) begin
                        w_sub_nx = r_sub + OS_W'(1);
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    assign busy_o       = (r_state == S_COUNT);
    assign bit_idx_o    = r_idx;
    assign bit_strobe_o = r_strobe;
    assign done_o       = r_done;
    assign last_bit_o   = (r_state == S_COUNT) && w_last_idx;

endmodule

// File: tb/tb_uart_frame_bit_counter.sv
// Self-checking bench: two instances (OVERSAMPLE 1 and 16) checked every cycle against a
// tick-count reference model, plus a directed vector table and corner-case sequences.
module tb_uart_frame_bit_counter;

    localparam int OS_A  = 1;
    localparam int OS_B  = 16;
    localparam int MAXB  = 12;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       st;
    logic [3:0] ln;
    logic       tk;

    logic       a_busy, a_str, a_last, a_done;
    logic [3:0] a_idx;
    logic       b_busy, b_str, b_last, b_done;
    logic [3:0] b_idx;

    uart_frame_bit_counter #(.MAX_BITS(MAXB), .OVERSAMPLE(OS_A)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .start_i(st), .len_i(ln), .tick_i(tk),
        .busy_o(a_busy), .bit_idx_o(a_idx), .bit_strobe_o(a_str), .last_bit_o(a_last), .done_o(a_done)
    );

    uart_frame_bit_counter #(.MAX_BITS(MAXB), .OVERSAMPLE(OS_B)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .start_i(st), .len_i(ln), .tick_i(tk),
        .busy_o(b_busy), .bit_idx_o(b_idx), .bit_strobe_o(b_str), .last_bit_o(b_last), .done_o(b_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk;
    int n_fail;

    // Reference model: frame progress kept as total ticks consumed; bit index is ticks / OVERSAMPLE.
    int m_busy[2];
    int m_len[2];
    int m_t[2];
    int m_idx[2];
    int m_str[2];
    int m_done[2];

    int cnt_str[2];
    int cnt_done[2];

    typedef struct {
        logic       clr;
        logic       st;
        logic [3:0] ln;
        logic       tk;
        logic       busy;
        int         idx;
        logic       str;
        logic       done;
        logic       last;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_len[k] = 0; m_t[k] = 0;
            m_idx[k]  = 0; m_str[k] = 0; m_done[k] = 0;
        end
    endtask

    task automatic model_update(input int k, input bit c, input bit s, input int l, input bit t);
        int os;
        os = (k == 0) ? OS_A : OS_B;
        m_str[k]  = 0;
        m_done[k] = 0;
        if (c) begin
            m_busy[k] = 0; m_idx[k] = 0; m_t[k] = 0;
        end else if (m_busy[k] != 0) begin
            if (t) begin
                m_t[k]++;
                if (m_t[k] % os == 0) m_str[k] = 1;
                if (m_t[k] == m_len[k] * os) begin
                    m_done[k] = 1;
`ifdef UART_BIT_COUNTER_RELOAD_EN
                    if (s && l != 0) begin
                        m_len[k] = (l > MAXB) ? MAXB : l;
                        m_t[k]   = 0;
                        m_idx[k] = 0;
                    end else begin
                        m_busy[k] = 0;
                    end
`else
                    m_busy[k] = 0;
`endif
                end else begin
                    m_idx[k] = m_t[k] / os;
                end
            end
        end else if (s && l != 0) begin
            m_busy[k] = 1;
            m_len[k]  = (l > MAXB) ? MAXB : l;
            m_t[k]    = 0;
            m_idx[k]  = 0;
        end
    endtask

    task automatic compare_model();
        int exp_last;
        for (int k = 0; k < 2; k++) begin
            exp_last = (m_busy[k] != 0 && m_idx[k] == m_len[k] - 1) ? 1 : 0;
            if (k == 0) begin
                chk("A.busy", int'(a_busy), m_busy[0]);
                chk("A.idx",  int'(a_idx),  m_idx[0]);
                chk("A.strobe", int'(a_str), m_str[0]);
                chk("A.done", int'(a_done), m_done[0]);
                chk("A.last", int'(a_last), exp_last);
            end else begin
                chk("B.busy", int'(b_busy), m_busy[1]);
                chk("B.idx",  int'(b_idx),  m_idx[1]);
                chk("B.strobe", int'(b_str), m_str[1]);
                chk("B.done", int'(b_done), m_done[1]);
                chk("B.last", int'(b_last), exp_last);
            end
        end
    endtask

    // Called at a falling edge: drives inputs, lets one rising edge pass, checks at the next falling edge.
    task automatic step(input bit c, input bit s, input int l, input bit t);
        clr = c; st = s; ln = 4'(l); tk = t;
        @(posedge clk);
        model_update(0, c, s, l, t);
        model_update(1, c, s, l, t);
        @(negedge clk);
        compare_model();
        if (a_str)  cnt_str[0]++;
        if (a_done) cnt_done[0]++;
        if (b_str)  cnt_str[1]++;
        if (b_done) cnt_done[1]++;
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 2; k++) begin
            cnt_str[k]  = 0;
            cnt_done[k] = 0;
        end
    endtask

    task automatic async_reset();
        clr = 1'b0; st = 1'b0; ln = '0; tk = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst.A.busy", int'(a_busy), 0);
        chk("rst.A.idx",  int'(a_idx),  0);
        chk("rst.A.strobe", int'(a_str), 0);
        chk("rst.A.done", int'(a_done), 0);
        chk("rst.A.last", int'(a_last), 0);
        chk("rst.B.busy", int'(b_busy), 0);
        chk("rst.B.idx",  int'(b_idx),  0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        clear_counts();
        model_reset();
        rst_n = 1'b0; clr = 1'b0; st = 1'b0; ln = '0; tk = 1'b0;

        //                clr st  ln tk  busy idx str done last
        vt[0]  = '{1'b0, 1'b1, 4'd3,  1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b0, 4'd3,  1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 4'd3,  1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 4'd3,  1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 1'b0, 4'd3,  1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 4'd1,  1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1};
        vt[7]  = '{1'b1, 1'b1, 4'd1,  1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 4'd1,  1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 4'd1,  1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0};
        vt[10] = '{1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};
        vt[11] = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset.A.busy", int'(a_busy), 0);
        chk("reset.A.done", int'(a_done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            step(vt[i].clr, vt[i].st, int'(vt[i].ln), vt[i].tk);
            chk($sformatf("vec%0d.busy", i), int'(a_busy), int'(vt[i].busy));
            chk($sformatf("vec%0d.idx", i), int'(a_idx), vt[i].idx);
            chk($sformatf("vec%0d.strobe", i), int'(a_str), int'(vt[i].str));
            chk($sformatf("vec%0d.done", i), int'(a_done), int'(vt[i].done));
            chk($sformatf("vec%0d.last", i), int'(a_last), int'(vt[i].last));
        end

        // Reset mid-frame, then make sure nothing leaks out afterwards.
        step(1, 0, 0, 0);
        step(0, 1, 10, 0);
        repeat (4) step(0, 0, 10, 1);
        async_reset();
        clear_counts();
        repeat (5) step(0, 0, 0, 0);
        chk("postrst.done_cnt", cnt_done[0], 0);

        // Basic frame: 10 bits, ticks spaced 3 cycles apart.
        step(1, 0, 0, 0);
        step(0, 1, 10, 0);
        clear_counts();
        for (int b = 0; b < 10; b++) begin
            step(0, 0, 10, 1);
            chk("basic.idx_after_tick", int'(a_idx), (b == 9) ? 9 : b + 1);
            step(0, 0, 10, 0);
            step(0, 0, 10, 0);
        end
        chk("basic.strobes", cnt_str[0], 10);
        chk("basic.dones", cnt_done[0], 1);

        // Oversampled frame on instance B: 3 bits of 16 ticks.
        step(1, 0, 0, 0);
        step(0, 1, 3, 0);
        clear_counts();
        for (int t = 1; t <= 48; t++) begin
            step(0, 0, 3, 1);
            if (t == 47) chk("os16.done_early", int'(b_done), 0);
            if (t == 48) chk("os16.done_at48", int'(b_done), 1);
        end
        chk("os16.strobes", cnt_str[1], 3);
        chk("os16.dones", cnt_done[1], 1);

        // Length 0 is ignored.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("len0.busy", int'(a_busy), 0);

        // Length above MAX_BITS saturates.
        step(0, 1, 15, 0);
        clear_counts();
        for (int t = 1; t <= 12; t++) step(0, 0, 15, 1);
        chk("len15.done_at12", int'(a_done), 1);
        chk("len15.strobes", cnt_str[0], 12);

        // Single-bit frame.
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        chk("len1.last", int'(a_last), 1);
        step(0, 0, 1, 1);
        chk("len1.done", int'(a_done), 1);

        // Clear coincident with the final tick.
        step(1, 0, 0, 0);
        step(0, 1, 8, 0);
        repeat (7) step(0, 0, 8, 1);
        step(1, 0, 8, 1);
        chk("clrfinal.strobe", int'(a_str), 0);
        chk("clrfinal.done", int'(a_done), 0);
        chk("clrfinal.busy", int'(a_busy), 0);
        chk("clrfinal.idx", int'(a_idx), 0);

        // Back-to-back: len 10 then len 11, start held on the final tick.
        step(1, 0, 0, 0);
        step(0, 1, 10, 0);
        repeat (9) step(0, 0, 10, 1);
        step(0, 1, 11, 1);
        chk("b2b.done_first", int'(a_done), 1);
`ifdef UART_BIT_COUNTER_RELOAD_EN
        chk("b2b.busy_kept", int'(a_busy), 1);
`else
        chk("b2b.busy_dropped", int'(a_busy), 0);
        step(0, 0, 11, 0);
        chk("b2b.still_idle", int'(a_busy), 0);
        step(0, 1, 11, 0);
        chk("b2b.restart", int'(a_busy), 1);
`endif
        clear_counts();
        repeat (11) step(0, 0, 11, 1);
        chk("b2b.second_strobes", cnt_str[0], 11);
        chk("b2b.second_done", cnt_done[0], 1);
        chk("b2b.second_end_busy", int'(a_busy), 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 799) == 0) async_reset();
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_frame_bit_counter.md
Name: uart_frame_bit_counter

Overview:
Parametrised successor to the UART Tx bit counter. Counts the bits of one serial frame whose length is set per frame at run time, with optional baud oversampling. Provides bit index, last-bit flag, bit strobe and a done pulse to the Tx/Rx shift FSM. Sits between the baud-tick generator and the frame shifter.

Parameters:
MAX_BITS, 12, largest frame length in bits (start + 8 data + parity + 2 stop); legal range 2..255.
OVERSAMPLE, 1, baud ticks per bit; 1 = no oversampling; legal range 1..64.
Localparams:
- LEN_W = $clog2(MAX_BITS+1)
- OS_W = max(1, $clog2(OVERSAMPLE))

Ports:
clk_i  input  1  system clock; all logic on its rising edge.
rst_ni  input  1  asynchronous, active-low reset.
clear_i  input  1  synchronous abort; returns block to IDLE.
start_i  input  1  request new frame; sampled in IDLE.
len_i  input  LEN_W  frame length in bits; sampled with start_i.
tick_i  input  1  baud tick, one clk_i cycle wide.
busy_o  output  1  high while a frame is being counted.
bit_idx_o  output  LEN_W  index of current bit, 0-based.
bit_strobe_o  output  1  one-cycle pulse when a bit period completes.
last_bit_o  output  1  high while bit_idx_o == len_q-1 in COUNT.
done_o  output  1  one-cycle pulse after the final bit period completes.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state = IDLE; bit_idx_o, tick sub-counter, len_q, bit_strobe_o, done_o = 0.
  - busy_o = 0, last_bit_o = 0.
- State machine has two states, IDLE and COUNT. busy_o = (state == COUNT).
- IDLE:
  - start_i=1 and len_i!=0 -> latch len_q = min(len_i, MAX_BITS); bit_idx=0; sub-counter=0; go to COUNT next cycle.
  - start_i=1 and len_i==0 -> ignored, stay in IDLE.
  - tick_i ignored.
- COUNT:
  - Each tick_i increments the sub-counter.
  - When the sub-counter reaches OVERSAMPLE-1 and tick_i=1, the bit period completes:
    - sub-counter -> 0;
    - bit_strobe_o=1 on the next cycle;
    - if bit_idx == len_q-1: done_o=1 on the next cycle and state -> IDLE; otherwise bit_idx++.
  - Cycles with tick_i=0 change nothing.
  - start_i is ignored in COUNT (but see the optional feature).
- All outputs are registered except last_bit_o, which is decoded combinationally from registered state.
- Latency: start_i to busy_o is 1 cycle. Final completing tick_i to done_o is 1 cycle; busy_o falls in the same cycle done_o rises.
- Total frame duration = len_q × OVERSAMPLE ticks.
- clear_i has priority over start_i and tick_i. It forces IDLE, bit_idx=0, sub-counter=0 and suppresses done_o/bit_strobe_o that cycle. No done_o is issued for an aborted frame.
- Reset or clear mid-frame: no partial done_o; a subsequent start_i begins cleanly.
- len_q is held constant for the whole frame; len_i changes during COUNT have no effect.
- len_i==1: a single bit; last_bit_o is high for the whole frame.
- No wrap-around: bit_idx never exceeds len_q-1.

Optional Feature:
- Macro UART_BIT_COUNTER_RELOAD_EN.
- Defined: start_i=1 (with len_i!=0) in the same cycle as the final completing tick starts the next frame back-to-back.
  - done_o still pulses.
  - busy_o stays high.
  - bit_idx -> 0 and len_q reloads from len_i.
  - There is no IDLE cycle between frames.
- Undefined: start_i in COUNT is always ignored, including the final cycle. The block must pass through IDLE for at least 1 cycle, and start_i must be reasserted there.

Test Plan:
1. Reset mid-frame: OVERSAMPLE=1, len_i=10, start, 4 ticks, pull rst_ni low asynchronously -> all outputs 0 immediately. No done_o after release.
2. Basic frame: OVERSAMPLE=1, len_i=10, start, then 10 ticks spaced 3 cycles apart:
   - bit_strobe_o pulses 10 times;
   - bit_idx_o steps 0..9;
   - last_bit_o is high only while idx=9;
   - done_o pulses once, 1 cycle after the 10th tick, with busy_o falling in the same cycle.
3. Oversampling: OVERSAMPLE=16, len_i=3, continuous ticks -> bit_strobe_o every 16 ticks; done_o after tick 48; bit_idx_o 0,1,2.
4. Boundary lengths:
   - len_i=0 -> stays IDLE, busy_o=0.
   - len_i=15 with MAX_BITS=12 -> done_o after 12 bits.
   - len_i=1 -> done_o after 1 bit, last_bit_o high throughout.
5. clear_i coincident with the final tick of a len_i=8 frame -> no done_o, no bit_strobe_o, IDLE next cycle, bit_idx_o=0.
6. Back-to-back: len_i=10 then len_i=11, start_i held on the final tick:
   - with UART_BIT_COUNTER_RELOAD_EN -> busy_o never drops; second frame counts 11 bits.
   - without it -> busy_o low for ≥1 cycle; second frame starts only after start_i is reasserted in IDLE.
